// File: rtl/bus_arbiter_8ch.sv
// Eight-requester arbiter with grant hold, bounded tenure, forced hand-off and a one-cycle idle gap.
// Define ARBITER_RR_EN for round-robin arbitration; default build is fixed priority (highest index wins).
module bus_arbiter_8ch #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       preempt
);

  typedef enum logic [1:0] {IDLE, GRANT, HANDOFF} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [2:0]       last_owner, last_nxt;
  logic [7:0]       grant_nxt;
  logic [2:0]       idx_nxt;
  logic             valid_nxt;
  logic             preempt_nxt;

  logic [7:0]       arb_req;
  logic             arb_found;
  logic [2:0]       arb_idx;
  logic [2:0]       cand;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  // preempt is only ever high during HANDOFF, and last_owner still names the preempted owner
  always_comb begin
    arb_req   = req;
    arb_found = 1'b0;
    arb_idx   = 3'd0;
    cand      = 3'd0;
    if (state == HANDOFF && preempt)
      arb_req[last_owner] = 1'b0;
`ifdef ARBITER_RR_EN
    for (int k = 7; k >= 0; k--) begin
      cand = last_owner + 3'(k + 1);
      if (arb_req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
`else
    for (int i = 0; i < 8; i++) begin
      if (arb_req[i]) begin
        arb_found = 1'b1;
        arb_idx   = 3'(i);
      end
    end
`endif
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    last_nxt    = last_owner;
    grant_nxt   = grant;
    idx_nxt     = grant_idx;
    valid_nxt   = grant_valid;
    preempt_nxt = 1'b0;
    case (state)
      IDLE, HANDOFF: begin
        if (arb_found) begin
          state_nxt = GRANT;
          hold_nxt  = CNT_W'(1);
          last_nxt  = arb_idx;
          grant_nxt = 8'b1 << arb_idx;
          idx_nxt   = arb_idx;
          valid_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
          hold_nxt  = '0;
          grant_nxt = 8'h00;
          idx_nxt   = 3'd0;
          valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        // an owner dropping its request wins over a simultaneous hold-limit hit
        if (!req[grant_idx] || (hold_cnt == HOLD_MAX && (req & ~grant) != 8'h00)) begin
          state_nxt   = HANDOFF;
          preempt_nxt = req[grant_idx];
          hold_nxt    = '0;
          grant_nxt   = 8'h00;
          idx_nxt     = 3'd0;
          valid_nxt   = 1'b0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
        grant_nxt = 8'h00;
        idx_nxt   = 3'd0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      last_owner  <= 3'd7;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      last_owner  <= last_nxt;
      grant       <= grant_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      preempt     <= preempt_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_8ch.sv
// Directed bench for bus_arbiter_8ch in its default fixed-priority build with MAX_HOLD = 4.
module tb_bus_arbiter_8ch;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  int checks;
  int failures;

  bus_arbiter_8ch #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] i,
                            input logic v, input logic p);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".idx"}, 32'(grant_idx), 32'(i));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(v));
    chk({tag, ".preempt"}, 32'(preempt), 32'(p));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 8'h00;
    #1;
    expect_out("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    expect_out("post_rst", 8'h00, 3'd0, 1'b0, 1'b0);

    // single request: grant after one edge
    req = 8'h08;
    step();
    expect_out("single", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    step();
    expect_out("single_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    expect_out("idle0", 8'h00, 3'd0, 1'b0, 1'b0);

    // fixed priority: 7 beats 0, then normal hand-off to 0 with one dead cycle
    req = 8'h81;
    step();
    expect_out("prio7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h01;
    step();
    expect_out("prio_gap", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    expect_out("prio0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step();
    step();
    expect_out("idle1", 8'h00, 3'd0, 1'b0, 1'b0);

    // forced release: 7 for 4 cycles, gap with preempt, 1 for 4 cycles, gap, 7 again
    req = 8'h82;
    for (int c = 0; c < 4; c++) begin
      step();
      expect_out($sformatf("force7_%0d", c), 8'h80, 3'd7, 1'b1, 1'b0);
    end
    step();
    expect_out("force_gap1", 8'h00, 3'd0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      expect_out($sformatf("force1_%0d", c), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    step();
    expect_out("force_gap2", 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    expect_out("force7_back", 8'h80, 3'd7, 1'b1, 1'b0);

    // owner drops at the hold limit: normal release, no preempt
    for (int c = 0; c < 3; c++) step();
    expect_out("limit7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h02;
    step();
    expect_out("limit_gap", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    expect_out("limit1", 8'h02, 3'd1, 1'b1, 1'b0);
    req = 8'h00;
    step();
    step();

    // short request inside another tenure is never served
    req = 8'h80;
    step();
    req = 8'h84;
    step();
    step();
    req = 8'h80;
    step();
    step();
    expect_out("pulse_ignored", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h00;
    step();
    step();

    // lone owner holds indefinitely
    req = 8'h20;
    for (int c = 0; c < 40; c++) begin
      step();
      chk($sformatf("lone_grant_%0d", c), 32'(grant), 32'h20);
      chk($sformatf("lone_preempt_%0d", c), 32'(preempt), 32'h0);
    end
    req = 8'h00;
    step();
    step();

    // asynchronous reset mid-grant
    req = 8'h04;
    step();
    expect_out("pre_arst", 8'h04, 3'd2, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    expect_out("arst", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    req = 8'h00;
    step();
    expect_out("arst_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
